// File: rtl/blit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : blit_ctrl
// Purpose  : Rectangular VRAM copy/fill engine driving the vram_arb blit port.
// Revision : 1.0 - initial release
// ============================================================================
module blit_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              reg_wr_en_i,
    input  logic [2:0]        reg_num_i,
    input  logic [15:0]       reg_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              vram_sel_o,
    input  logic              vram_ack_i,
    output logic              vram_wr_o,
    output logic [3:0]        vram_wr_mask_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [15:0]       vram_data_o,
    input  logic [15:0]       vram_data_i
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_REQ  = 3'd1;
    localparam logic [2:0] c_RD_DATA = 3'd2;
    localparam logic [2:0] c_WR_REQ  = 3'd3;
    localparam logic [2:0] c_ADVANCE = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    localparam logic [ADDR_W-1:0] c_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_src_addr, r_dst_addr, r_src_mod, r_dst_mod;
    logic [ADDR_W-1:0] r_src, r_dst;
    logic [15:0]       r_width, r_height, r_const;
    logic [15:0]       r_wcnt, r_hcnt, r_data;
    logic              r_fill, r_abort;
    logic [3:0]        r_mask;

    logic w_busy, w_ctrl_wr, w_abort_only, w_go, w_abort, w_row_end, w_last;
    logic w_unused_ctrl_bits;

    assign w_busy       = (r_state != c_IDLE) && (r_state != c_DONE);
    assign w_ctrl_wr    = reg_wr_en_i && (reg_num_i == 3'd7);
    // A bare ABORT (no FILL, no mask) while idle is not a GO.
    assign w_abort_only = reg_data_i[1] && !reg_data_i[0] && (reg_data_i[7:4] == 4'd0);
    assign w_go         = w_ctrl_wr && !w_busy && !w_abort_only;
    assign w_abort      = r_abort || (w_ctrl_wr && w_busy && reg_data_i[1]);
    assign w_row_end    = (r_wcnt == 16'd1);
    assign w_last       = w_row_end && (r_hcnt == 16'd1);

    assign w_unused_ctrl_bits = ^{reg_data_i[15:8], reg_data_i[3:2]};

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state    <= c_IDLE;
            r_src_addr <= '0;
            r_dst_addr <= '0;
            r_src_mod  <= '0;
            r_dst_mod  <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_width    <= 16'd0;
            r_height   <= 16'd0;
            r_const    <= 16'd0;
            r_wcnt     <= 16'd0;
            r_hcnt     <= 16'd0;
            r_data     <= 16'd0;
            r_fill     <= 1'b0;
            r_abort    <= 1'b0;
            r_mask     <= 4'd0;
        end else begin
            if (reg_wr_en_i && !w_busy) begin
                case (reg_num_i)
                    3'd0: r_src_addr <= ADDR_W'(reg_data_i);
                    3'd1: r_dst_addr <= ADDR_W'(reg_data_i);
                    3'd2: r_src_mod  <= ADDR_W'($signed(reg_data_i));
                    3'd3: r_dst_mod  <= ADDR_W'($signed(reg_data_i));
                    3'd4: r_width    <= reg_data_i;
                    3'd5: r_height   <= reg_data_i;
                    3'd6: r_const    <= reg_data_i;
                    default: ;
                endcase
            end
            if (w_ctrl_wr && w_busy && reg_data_i[1])
                r_abort <= 1'b1;

            case (r_state)
                c_IDLE, c_DONE: begin
                    r_abort <= 1'b0;
                    if (w_go) begin
                        r_src  <= r_src_addr;
                        r_dst  <= r_dst_addr;
                        r_wcnt <= r_width;
                        r_hcnt <= r_height;
                        r_fill <= reg_data_i[0];
                        r_mask <= reg_data_i[7:4];
                        if ((r_width == 16'd0) || (r_height == 16'd0))
                            r_state <= c_DONE;
                        else if (reg_data_i[0])
                            r_state <= c_WR_REQ;
                        else
                            r_state <= c_RD_REQ;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RD_REQ: begin
                    // An aborted read still waits for its ack, then is dropped.
                    if (vram_ack_i)
                        r_state <= w_abort ? c_DONE : c_RD_DATA;
                end
                c_RD_DATA: begin
                    r_data  <= vram_data_i;
                    r_state <= w_abort ? c_DONE : c_WR_REQ;
                end
                c_WR_REQ: begin
                    if (vram_ack_i)
                        r_state <= w_abort ? c_DONE : c_ADVANCE;
                end
                c_ADVANCE: begin
                    if (w_row_end) begin
                        r_src  <= r_src + c_ONE + r_src_mod;
                        r_dst  <= r_dst + c_ONE + r_dst_mod;
                        r_wcnt <= r_width;
                        r_hcnt <= r_hcnt - 16'd1;
                    end else begin
                        r_src  <= r_src + c_ONE;
                        r_dst  <= r_dst + c_ONE;
                        r_wcnt <= r_wcnt - 16'd1;
                    end
                    if (w_last || w_abort)
                        r_state <= c_DONE;
                    else if (r_fill)
                        r_state <= c_WR_REQ;
                    else
                        r_state <= c_RD_REQ;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy_o         = w_busy;
    assign done_o         = (r_state == c_DONE);
    assign vram_sel_o     = (r_state == c_RD_REQ) || (r_state == c_WR_REQ);
    assign vram_wr_o      = (r_state == c_WR_REQ);
    assign vram_wr_mask_o = (r_state == c_WR_REQ) ? r_mask : 4'd0;
    assign vram_addr_o    = (r_state == c_RD_REQ) ? r_src :
                            (r_state == c_WR_REQ) ? r_dst : '0;
    assign vram_data_o    = (r_state != c_WR_REQ) ? 16'd0 :
                            (r_fill ? r_const : r_data);

endmodule
`default_nettype wire

// File: tb/tb_blit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_blit_ctrl
// Purpose  : Directed, table-driven bench for blit_ctrl with a VRAM/arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blit_ctrl;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        reg_wr_en_i = 1'b0;
    logic [2:0]  reg_num_i = 3'd0;
    logic [15:0] reg_data_i = 16'd0;
    logic        busy_o, done_o, vram_sel_o, vram_wr_o;
    logic        vram_ack_i = 1'b0;
    logic [3:0]  vram_wr_mask_o;
    logic [15:0] vram_addr_o, vram_data_o;
    logic [15:0] vram_data_i = 16'd0;

    blit_ctrl #(.ADDR_W(16)) dut (
        .clk(clk), .reset_i(reset_i),
        .reg_wr_en_i(reg_wr_en_i), .reg_num_i(reg_num_i), .reg_data_i(reg_data_i),
        .busy_o(busy_o), .done_o(done_o),
        .vram_sel_o(vram_sel_o), .vram_ack_i(vram_ack_i), .vram_wr_o(vram_wr_o),
        .vram_wr_mask_o(vram_wr_mask_o), .vram_addr_o(vram_addr_o),
        .vram_data_o(vram_data_o), .vram_data_i(vram_data_i)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int stall = 0;
    int wcnt = 0;
    int n_acks = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  mask;
    } wr_t;
    wr_t wlog[$];

    logic [15:0] mem [0:65535];

    // VRAM model: ack accepted on the clock edge, read data valid the next cycle
    always @(posedge clk) begin
        if (vram_sel_o && vram_ack_i && !reset_i) begin
            n_acks++;
            if (vram_wr_o) begin
                logic [15:0] w;
                w = mem[vram_addr_o];
                for (int i = 0; i < 4; i++)
                    if (vram_wr_mask_o[i]) w[4*i +: 4] = vram_data_o[4*i +: 4];
                mem[vram_addr_o] = w;
                wlog.push_back('{vram_addr_o, vram_data_o, vram_wr_mask_o});
            end else begin
                vram_data_i <= mem[vram_addr_o];
            end
        end
    end

    // Request-stability monitor, then arbiter ack decision for the coming edge
    logic        prev_sel = 1'b0;
    logic        prev_ack = 1'b0;
    logic [36:0] prev_req = '0;
    always @(negedge clk) begin
        if (vram_sel_o && prev_sel) begin
            tests++;
            if (prev_ack) begin
                fails++;
                $display("FAIL sel_b2b: sel high right after an acked request at %0t", $time);
            end else if ({vram_addr_o, vram_wr_o, vram_data_o, vram_wr_mask_o} !== prev_req) begin
                fails++;
                $display("FAIL req_stable: got %h required %h",
                         {vram_addr_o, vram_wr_o, vram_data_o, vram_wr_mask_o}, prev_req);
            end
        end
        prev_sel = vram_sel_o;
        prev_req = {vram_addr_o, vram_wr_o, vram_data_o, vram_wr_mask_o};
        if (vram_sel_o && !reset_i) begin
            if (wcnt >= stall) begin vram_ack_i = 1'b1; wcnt = 0; end
            else begin vram_ack_i = 1'b0; wcnt++; end
        end else begin
            vram_ack_i = 1'b0;
            wcnt = 0;
        end
        prev_ack = vram_ack_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [2:0] num, input logic [15:0] data);
        @(negedge clk);
        reg_wr_en_i = 1'b1;
        reg_num_i   = num;
        reg_data_i  = data;
        @(negedge clk);
        reg_wr_en_i = 1'b0;
    endtask

    // Called at the negedge of cycle 1 after GO; returns the cycle done_o is seen, -1 on timeout
    task automatic wait_done(output int lat);
        int c;
        c = 1;
        while (!done_o && c < 6000) begin
            @(negedge clk);
            c++;
        end
        lat = done_o ? c : -1;
    endtask

    typedef struct {
        bit          fill;
        logic [15:0] src, dst, smod, dmod, width, height, cval;
        logic [3:0]  mask;
        int          stl, lat, nw;
        logic [15:0] a0, d0, an, dn;
    } vec_t;

    function automatic vec_t mk(input bit fill, input logic [15:0] src, dst, smod, dmod,
                                width, height, cval, input logic [3:0] mask,
                                input int stl, lat, nw,
                                input logic [15:0] a0, d0, an, dn);
        vec_t v;
        v.fill = fill; v.src = src; v.dst = dst; v.smod = smod; v.dmod = dmod;
        v.width = width; v.height = height; v.cval = cval; v.mask = mask;
        v.stl = stl; v.lat = lat; v.nw = nw;
        v.a0 = a0; v.d0 = d0; v.an = an; v.dn = dn;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        int lat, n0, cnt_sel, cnt_done;

        //             fill src      dst      smod     dmod     w      h      const    mask  stl lat nw  a0       d0       an       dn
        vecs[0] = mk(1, 16'h0000, 16'h1000, 16'h0000, 16'h0006, 16'd4, 16'd2, 16'hA5A5, 4'hF, 0, 17, 8, 16'h1000, 16'hA5A5, 16'h100D, 16'hA5A5);
        vecs[1] = mk(0, 16'h0200, 16'h0300, 16'h0000, 16'h0000, 16'd3, 16'd1, 16'h0000, 4'hF, 0, 13, 3, 16'h0300, 16'h1111, 16'h0302, 16'h3333);
        vecs[2] = mk(0, 16'h0200, 16'h0300, 16'h0000, 16'h0000, 16'd3, 16'd1, 16'h0000, 4'hF, 5, 43, 3, 16'h0300, 16'h1111, 16'h0302, 16'h3333);
        vecs[3] = mk(1, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 16'd4, 16'd1, 16'h5A5A, 4'h3, 0,  9, 4, 16'hFFFE, 16'h5A5A, 16'h0001, 16'h5A5A);
        vecs[4] = mk(0, 16'h0200, 16'h0400, 16'hFFFE, 16'h0002, 16'd2, 16'd2, 16'h0000, 4'hF, 0, 17, 4, 16'h0400, 16'h1111, 16'h0405, 16'h2222);
        vecs[5] = mk(1, 16'h0000, 16'h0800, 16'h0000, 16'h0000, 16'd0, 16'd5, 16'h4444, 4'hF, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        vecs[6] = mk(0, 16'h0200, 16'h0800, 16'h0000, 16'h0000, 16'd3, 16'd0, 16'h0000, 4'hF, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        vecs[7] = mk(1, 16'h0000, 16'h0600, 16'h0000, 16'h0000, 16'd2, 16'd1, 16'h1234, 4'hC, 2,  9, 2, 16'h0600, 16'h1234, 16'h0601, 16'h1234);

        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0200] = 16'h1111;
        mem[16'h0201] = 16'h2222;
        mem[16'h0202] = 16'h3333;
        mem[16'h0EEE] = 16'hDEAD;

        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_sel",  vram_sel_o, 0);
        chk("rst_wr",   vram_wr_o, 0);
        chk("rst_mask", vram_wr_mask_o, 0);

        for (int v = 0; v < 8; v++) begin
            write_reg(3'd0, vecs[v].src);
            write_reg(3'd1, vecs[v].dst);
            write_reg(3'd2, vecs[v].smod);
            write_reg(3'd3, vecs[v].dmod);
            write_reg(3'd4, vecs[v].width);
            write_reg(3'd5, vecs[v].height);
            write_reg(3'd6, vecs[v].cval);
            stall = vecs[v].stl;
            wlog.delete();
            n0 = n_acks;
            write_reg(3'd7, {8'h00, vecs[v].mask, 3'b000, vecs[v].fill});
            chk($sformatf("v%0d_busy_start", v), busy_o, (vecs[v].lat > 1) ? 1 : 0);
            wait_done(lat);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            chk($sformatf("v%0d_busy_at_done", v), busy_o, 0);
            chk($sformatf("v%0d_nwrites", v), wlog.size(), vecs[v].nw);
            if (vecs[v].nw == 0)
                chk($sformatf("v%0d_no_requests", v), n_acks - n0, 0);
            if (wlog.size() > 0 && vecs[v].nw > 0) begin
                chk($sformatf("v%0d_first_addr", v), wlog[0].addr, vecs[v].a0);
                chk($sformatf("v%0d_first_data", v), wlog[0].data, vecs[v].d0);
                chk($sformatf("v%0d_last_addr", v), wlog[wlog.size()-1].addr, vecs[v].an);
                chk($sformatf("v%0d_last_data", v), wlog[wlog.size()-1].data, vecs[v].dn);
                foreach (wlog[k])
                    chk($sformatf("v%0d_mask%0d", v, k), wlog[k].mask, vecs[v].mask);
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_width", v), done_o, 0);
        end
        chk("copy_mem_0301", mem[16'h0301], 16'h2222);
        chk("copy2d_mem_0404", mem[16'h0404], 16'h1111);

        // Bare ABORT while idle must not start anything
        write_reg(3'd7, 16'h0002);
        cnt_done = 0;
        cnt_sel  = 0;
        repeat (4) begin
            if (done_o || busy_o) cnt_done++;
            if (vram_sel_o) cnt_sel++;
            @(negedge clk);
        end
        chk("idle_abort_no_op", cnt_done + cnt_sel, 0);

        // Reset in the middle of a stalled read request
        write_reg(3'd0, 16'h0200);
        write_reg(3'd1, 16'h0700);
        write_reg(3'd4, 16'd3);
        write_reg(3'd5, 16'd1);
        stall = 8;
        wlog.delete();
        write_reg(3'd7, 16'h00F0);
        chk("rstmid_in_rdreq", {vram_sel_o, vram_wr_o}, 2'b10);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        chk("rstmid_sel",  vram_sel_o, 0);
        chk("rstmid_busy", busy_o, 0);
        chk("rstmid_done", done_o, 0);
        cnt_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o || vram_sel_o) cnt_done++;
        end
        chk("rstmid_quiet", cnt_done, 0);
        chk("rstmid_no_writes", wlog.size(), 0);

        // Registers were cleared by reset: GO now has WIDTH=0
        stall = 0;
        n0 = n_acks;
        write_reg(3'd7, 16'h00F0);
        wait_done(lat);
        chk("w0_latency", lat, 1);
        chk("w0_no_requests", n_acks - n0, 0);

        // Abort a large fill while a write is stalled
        write_reg(3'd0, 16'h0200);
        write_reg(3'd1, 16'h2000);
        write_reg(3'd3, 16'h0000);
        write_reg(3'd4, 16'd64);
        write_reg(3'd5, 16'd64);
        write_reg(3'd6, 16'h7777);
        stall = 8;
        wlog.delete();
        write_reg(3'd7, 16'h00F1);
        write_reg(3'd0, 16'h0EEE);
        lat = 0;
        while (!(wlog.size() >= 2 && vram_sel_o) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("abort_reached_3rd_write", lat < 200, 1);
        n0 = wlog.size();
        write_reg(3'd7, 16'h0002);
        wait_done(lat);
        chk("abort_done_seen", lat > 0, 1);
        chk("abort_busy", busy_o, 0);
        chk("abort_one_more_write", wlog.size(), n0 + 1);
        if (wlog.size() > 0)
            chk("abort_last_addr", wlog[wlog.size()-1].addr, 16'h2002);
        cnt_done = 0;
        cnt_sel  = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_o) cnt_done++;
            if (vram_sel_o) cnt_sel++;
        end
        chk("abort_no_2nd_done", cnt_done, 0);
        chk("abort_no_more_sel", cnt_sel, 0);

        // SRC_ADDR written during the aborted fill must have been ignored
        stall = 0;
        wlog.delete();
        write_reg(3'd1, 16'h0500);
        write_reg(3'd4, 16'd1);
        write_reg(3'd5, 16'd1);
        write_reg(3'd7, 16'h00F0);
        wait_done(lat);
        chk("srcign_latency", lat, 5);
        chk("srcign_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) begin
            chk("srcign_addr", wlog[0].addr, 16'h0500);
            chk("srcign_data", wlog[0].data, 16'h1111);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
